video_timing_gen: RTL
=====================

# video_timing_gen

Video timing and test-pattern source for the VP pipeline. It generates a complete raster (post_vs, post_hs, post_de, post_data) from a single pixel clock. The raster drives stream processors such as the frame filler, the scaler and the HDMI/RGB output, either in place of the camera/DDR path or for bring-up and verification. Timing is parameterised per resolution, and the pattern is selectable at frame granularity.

## Interface
- H_DISP, 12'd1280, active pixels per line
- H_FP, 12'd110, horizontal front porch (pixels)
- H_SYNC, 12'd40, hsync width (pixels)
- H_BP, 12'd220, horizontal back porch (pixels)
- V_DISP, 12'd720, active lines per frame
- V_FP, 12'd5, vertical front porch (lines)
- V_SYNC, 12'd5, vsync width (lines)
- V_BP, 12'd20, vertical back porch (lines)

- pre_clk  in  1  pixel clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- EN  in  1  generator enable
- mode  in  2  pattern select: 00 colour bars, 01 solid `color`, 10 grid, 11 checkerboard
- color  in  24  custom RGB888 colour used by modes 01/10/11
- post_clk  out  1  equals pre_clk
- post_vs  out  1  vsync, active-high
- post_hs  out  1  hsync, active-high
- post_de  out  1  active-video qualifier
- post_data  out  24  RGB888 pixel, 0 when post_de=0
- frame_start  out  1  one-cycle pulse with the first active pixel of each frame

## Operation
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP. 12-bit h_cnt counts 0..H_TOTAL-1 and wraps. 12-bit v_cnt increments on h wrap and wraps at V_TOTAL-1.
- Horizontal regions in h_cnt order: active [0,H_DISP), FP, SYNC, BP. Vertical regions in v_cnt order: active, FP, SYNC, BP.
- post_de = h active AND v active.
- post_hs = h in SYNC region.
- post_vs = v in SYNC region. vs edges coincide with h_cnt==0.
- FSM states:
  - IDLE: counters held at 0, all outputs 0. Goes to RUN when EN=1.
  - RUN: free-running raster. If EN=0 is sampled, go to DRAIN.
  - DRAIN: keeps running. Returns to IDLE after the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1). If EN=1 returns before that cycle, go back to RUN with no raster break.
- mode and color are latched at h=0, v=0 when entering RUN and on every frame wrap. Changes mid-frame take effect at the next frame.
- Patterns, using pixel coordinates x=h_cnt and y=v_cnt:
  - 00: eight bars, each H_DISP/8 wide, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index comes from a per-line sub-counter, with no divider. H_DISP must be a multiple of 8.
  - 01: latched color.
  - 10: FFFFFF where x[5:0]==0 or y[5:0]==0, else latched color.
  - 11: latched color where x[6]^y[6]==1, else 000000.

## Timing
- Every output is registered. Outputs in cycle n+1 reflect the counters in cycle n (1-cycle latency).
- The first pixel appears 2 cycles after EN is sampled high in IDLE: IDLE→RUN takes one cycle, the output register takes one. frame_start is asserted with that pixel.
- Reset, including reset mid-frame, asynchronously forces state=IDLE, counters=0, and post_vs/post_hs/post_de/frame_start/post_data=0.
- When EN toggles 1→0→1 within one frame, the raster continues with no change to h/v counts.
- post_data is 0 for every cycle in which post_de=0.

## Configuration
- VTG_FRAME_CNT_EN defined: adds output frame_cnt (16 bits). It resets to 0, increments on each frame_start, wraps at FFFF, and holds its value in IDLE.
- VTG_FRAME_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- vtg_pkg holds the mode encodings (MODE_BARS/SOLID/GRID/CHECK), the eight bar colour constants and the state encodings.
- One sub-module, vtg_pattern: a registered pixel-colour generator taking x, y, bar index, latched mode and colour. The top level holds the counters, FSM and sync decode.

## Test plan
All scenarios use H_DISP=16, H_FP=2, H_SYNC=2, H_BP=2, V_DISP=4, V_FP=V_SYNC=V_BP=1 (H_TOTAL=22, V_TOTAL=7, 154 cycles/frame).
- Assert EN for 3 frames, mode=00 -> per frame: 4 de runs of 16 cycles each; per line: hs high for 2 cycles starting 18 cycles after de rises; vs high for 22 cycles; frame_start pulses every 154 cycles; the line's pixels go in bar pairs FFFFFF,FFFFFF,FFFF00,... ending 000000,000000.
- Change mode 00→11 with color=123456 mid-frame -> the current frame stays bars; from the next frame, pixel (0,0)=000000 and no pixel value differs from 000000 or 123456.
- Drop EN at cycle 40 of a frame -> the frame completes all 154 cycles, then all outputs stay 0. Re-assert EN -> first de 2 cycles later.
- Pulse EN low for 10 cycles mid-frame -> frame_start period stays exactly 154, no missing de cycles.
- Assert rst mid-line with de=1 -> all outputs 0 in the same cycle. After release with EN=1, the raster restarts from h=0, v=0.
- With VTG_FRAME_CNT_EN defined, run 5 frames -> frame_cnt=5. After EN drop and drain, frame_cnt holds 5.

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared encodings for video_timing_gen: pattern modes, FSM states and colour-bar palette.
package vtg_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_GRID  = 2'b10,
        MODE_CHECK = 2'b11
    } vtg_mode_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        c = BAR_BLACK;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Registered pixel-colour generator; only the low coordinate bits matter to the grid/checker patterns.
module vtg_pattern
    import vtg_pkg::*;
(
    input  logic        pre_clk,
    input  logic        rst,
    input  logic        de,
    input  logic [6:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  bar_idx,
    input  vtg_mode_e   mode,
    input  logic [23:0] color,
    output logic [23:0] data
);

    logic [23:0] pix;

    always_comb begin
        pix = BAR_BLACK;
        case (mode)
            MODE_BARS:  pix = bar_color(bar_idx);
            MODE_SOLID: pix = color;
            MODE_GRID:  pix = (x[5:0] == 6'd0 || y[5:0] == 6'd0) ? BAR_WHITE : color;
            MODE_CHECK: pix = (x[6] ^ y[6]) ? color : BAR_BLACK;
            default:    pix = BAR_BLACK;
        endcase
    end

    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            data <= 24'h0;
        end else begin
            data <= de ? pix : 24'h0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing + test-pattern source. Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
//   state | meaning
//   IDLE  | counters held at 0, outputs 0
//   RUN   | free-running raster
//   DRAIN | raster finishes current frame, then IDLE unless EN returns
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter logic [11:0] H_DISP = 12'd1280,
    parameter logic [11:0] H_FP   = 12'd110,
    parameter logic [11:0] H_SYNC = 12'd40,
    parameter logic [11:0] H_BP   = 12'd220,
    parameter logic [11:0] V_DISP = 12'd720,
    parameter logic [11:0] V_FP   = 12'd5,
    parameter logic [11:0] V_SYNC = 12'd5,
    parameter logic [11:0] V_BP   = 12'd20
) (
    input  logic        pre_clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [1:0]  mode,
    input  logic [23:0] color,
    output logic        post_clk,
    output logic        post_vs,
    output logic        post_hs,
    output logic        post_de,
    output logic [23:0] post_data,
    output logic        frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [11:0] H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam logic [11:0] V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_SYNC_S = H_DISP + H_FP;
    localparam logic [11:0] H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam logic [11:0] V_SYNC_S = V_DISP + V_FP;
    localparam logic [11:0] V_SYNC_E = V_SYNC_S + V_SYNC;
    localparam logic [11:0] BAR_W    = H_DISP >> 3;

    logic [1:0]  state, state_nxt;
    logic [11:0] h_cnt, v_cnt;
    logic [11:0] bar_sub;
    logic [2:0]  bar_idx;
    vtg_mode_e   mode_q;
    logic [23:0] color_q;
    logic        active, h_last, frame_last, de_c, latch_cfg;

    assign post_clk   = pre_clk;
    assign active     = (state != ST_IDLE);
    assign h_last     = (h_cnt == H_TOTAL - 12'd1);
    assign frame_last = h_last && (v_cnt == V_TOTAL - 12'd1);
    assign de_c       = active && (h_cnt < H_DISP) && (v_cnt < V_DISP);
    assign latch_cfg  = (state == ST_IDLE && EN) || (active && frame_last);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (EN) state_nxt = ST_RUN;
            ST_RUN:   if (!EN) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (EN)              state_nxt = ST_RUN;
                else if (frame_last) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            h_cnt   <= 12'd0;
            v_cnt   <= 12'd0;
            bar_sub <= 12'd0;
            bar_idx <= 3'd0;
        end else begin
            state <= state_nxt;
            if (!active) begin
                h_cnt <= 12'd0;
                v_cnt <= 12'd0;
            end else begin
                h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
                if (h_last) v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
            end
            // bar index tracks h_cnt / BAR_W without a divider
            if (!active || h_last) begin
                bar_sub <= 12'd0;
                bar_idx <= 3'd0;
            end else if (h_cnt < H_DISP) begin
                if (bar_sub == BAR_W - 12'd1) begin
                    bar_sub <= 12'd0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_sub <= bar_sub + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_BARS;
            color_q <= 24'h0;
        end else if (latch_cfg) begin
            mode_q  <= vtg_mode_e'(mode);
            color_q <= color;
        end
    end

    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            post_de     <= 1'b0;
            post_hs     <= 1'b0;
            post_vs     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            post_de     <= de_c;
            post_hs     <= active && (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
            post_vs     <= active && (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
            frame_start <= active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (active && h_cnt == 12'd0 && v_cnt == 12'd0) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    vtg_pattern u_pattern (
        .pre_clk (pre_clk),
        .rst     (rst),
        .de      (de_c),
        .x       (h_cnt[6:0]),
        .y       (v_cnt[6:0]),
        .bar_idx (bar_idx),
        .mode    (mode_q),
        .color   (color_q),
        .data    (post_data)
    );

endmodule
